// File: rtl/inst_pair_queue.sv
// -----------------------------------------------------------------------------
// inst_pair_queue
//   Decoupling buffer between the IF/ID register and the single-issue
//   decode/dispatch stage. Each cycle it accepts one fetched pair:
//   inst1 at in_pc and inst2 at in_pc+4. It releases one instruction per
//   cycle, together with its PC, in strict FIFO order. It raises in_stall
//   to freeze IF/ID whenever fewer than two slots are free.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high (same effect as flush)
//   flush      in   empties the queue; same-cycle push/pop are discarded
//   in_valid   in   pair valid from IF/ID
//   in_pc      in   PC of inst1 (word aligned)
//   in_inst1   in   instruction at in_pc
//   in_inst2   in   instruction at in_pc+4
//   in_stall   out  queue cannot accept a pair (registered-count based)
//   out_valid  out  head entry valid
//   out_pc     out  PC of head instruction (first-word-fall-through)
//   out_inst   out  head instruction word
//   out_ready  in   consumer takes the head this cycle
//   occupancy  out  instructions currently held, 0..DEPTH
//
// Configuration
//   NOP_SQUASH_EN  when defined, all-zero instruction words (MIPS nop)
//                  are not stored; a pair writes 0, 1 or 2 entries.
// -----------------------------------------------------------------------------
module inst_pair_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_inst1,
    input  logic [31:0]   in_inst2,
    output logic          in_stall,
    output logic          out_valid,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_inst,
    input  logic          out_ready,
    output logic [AW:0]   occupancy
);

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic          keep1;
    logic          keep2;
    logic          push;
    logic          pop;
    logic [1:0]    push_cnt;
    logic [AW-1:0] wr_idx2;
    logic [AW:0]   count_next;
    logic [AW+1:0] count_chk;

    // Stall looks only at the registered count so there is no combinational
    // path from out_ready/in_valid back into the IF/ID freeze.
    assign in_stall           = (DEPTH_CNT - count) < (AW+1)'(2);
    assign out_valid          = (count != '0);
    assign {out_pc, out_inst} = mem[rd_ptr];
    assign occupancy          = count;

    always_comb begin
`ifdef NOP_SQUASH_EN
        keep1 = (in_inst1 != '0);
        keep2 = (in_inst2 != '0);
`else
        keep1 = 1'b1;
        keep2 = 1'b1;
`endif
    end

    always_comb begin
        push       = in_valid & ~in_stall & ~flush & ~rst;
        pop        = out_valid & out_ready & ~flush & ~rst;
        push_cnt   = push ? ({1'b0, keep1} + {1'b0, keep2}) : 2'd0;
        // inst2 lands right after inst1, or at wr_ptr itself if inst1 was squashed
        wr_idx2    = wr_ptr + {{(AW-1){1'b0}}, keep1};
        count_next = count + {{(AW-1){1'b0}}, push_cnt} - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(push_cnt);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
        end
    end

    // Storage is intentionally not cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (push && keep1) begin
            mem[wr_ptr] <= {in_pc, in_inst1};
        end
        if (push && keep2) begin
            mem[wr_idx2] <= {in_pc + 32'd4, in_inst2};
        end
    end

    // Widened next-count: an underflow wraps to a large value, so a single
    // upper bound catches both overflow and underflow.
    assign count_chk = {1'b0, count} + {{AW{1'b0}}, push_cnt} - {{(AW+1){1'b0}}, pop};

    a_count_bounds: assert property (@(posedge clk) disable iff (rst || flush)
        count_chk <= (AW+2)'(DEPTH));

endmodule

// File: tb/tb_inst_pair_queue.sv
module tb_inst_pair_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [31:0]   in_pc;
    logic [31:0]   in_inst1;
    logic [31:0]   in_inst2;
    logic          in_stall;
    logic          out_valid;
    logic [31:0]   out_pc;
    logic [31:0]   out_inst;
    logic          out_ready;
    logic [AW:0]   occupancy;

    int checks = 0;
    int errors = 0;

    inst_pair_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_inst1  (in_inst1),
        .in_inst2  (in_inst2),
        .in_stall  (in_stall),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] tag(input logic [31:0] pc);
        return 32'hA000_0000 | pc;
    endfunction

    task automatic drive_pair(input logic [31:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst1 = tag(pc);
        in_inst2 = tag(pc + 32'd4);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst1 = '0; in_inst2 = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_stall !== 1'b0) begin errors++; $display("FAIL reset_in_stall: got %b expected 0", in_stall); end
    endtask

    task automatic test_basic();
        in_valid = 1'b1; in_pc = 32'h100; in_inst1 = 32'h2001_0001; in_inst2 = 32'h2002_0002;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_inst !== 32'h2001_0001) begin
            errors++; $display("FAIL basic_first: got v=%b %h/%h expected 1 00000100/20010001", out_valid, out_pc, out_inst); end
        checks++; if (occupancy !== 4'd2) begin errors++; $display("FAIL basic_occ: got %0d expected 2", occupancy); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h104 || out_inst !== 32'h2002_0002) begin
            errors++; $display("FAIL basic_second: got v=%b %h/%h expected 1 00000104/20020002", out_valid, out_pc, out_inst); end
        tick();
        checks++; if (out_valid !== 1'b0 || occupancy !== 4'd0) begin
            errors++; $display("FAIL basic_empty: got v=%b occ=%0d expected 0 0", out_valid, occupancy); end
        out_ready = 1'b0;
    endtask

    task automatic test_fill_stall();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_pair(32'h1000 + 32'(8 * i));
            tick();
            checks++; if (occupancy !== 4'(2 * (i + 1))) begin
                errors++; $display("FAIL fill_occ[%0d]: got %0d expected %0d", i, occupancy, 2 * (i + 1)); end
            checks++; if (in_stall !== (i == 3)) begin
                errors++; $display("FAIL fill_stall[%0d]: got %b expected %b", i, in_stall, (i == 3)); end
        end
        drive_pair(32'h1020);
        tick();
        checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL held_occ: got %0d expected 8", occupancy); end
        out_ready = 1'b1;
        tick();
        checks++; if (occupancy !== 4'd7 || in_stall !== 1'b1 || out_pc !== 32'h1004) begin
            errors++; $display("FAIL pop1: got occ=%0d stall=%b pc=%h expected 7 1 00001004", occupancy, in_stall, out_pc); end
        tick();
        checks++; if (occupancy !== 4'd6 || in_stall !== 1'b0 || out_pc !== 32'h1008) begin
            errors++; $display("FAIL pop2: got occ=%0d stall=%b pc=%h expected 6 0 00001008", occupancy, in_stall, out_pc); end
        tick();
        in_valid = 1'b0;
        checks++; if (occupancy !== 4'd7 || out_pc !== 32'h100C) begin
            errors++; $display("FAIL accept_held: got occ=%0d pc=%h expected 7 0000100c", occupancy, out_pc); end
        for (int k = 0; k < 7; k++) begin
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100C + 32'(4 * k) || out_inst !== tag(32'h100C + 32'(4 * k))) begin
                errors++; $display("FAIL drain[%0d]: got v=%b %h/%h expected 1 %h/%h", k, out_valid, out_pc, out_inst,
                                   32'h100C + 32'(4 * k), tag(32'h100C + 32'(4 * k))); end
            tick();
        end
        checks++; if (out_valid !== 1'b0 || occupancy !== 4'd0) begin
            errors++; $display("FAIL drain_empty: got v=%b occ=%0d expected 0 0", out_valid, occupancy); end
        out_ready = 1'b0;
    endtask

    task automatic test_push_pop_same_cycle();
        out_ready = 1'b0;
        drive_pair(32'h3000); tick();
        drive_pair(32'h3008); tick();
        in_valid = 1'b0; out_ready = 1'b1; tick();
        checks++; if (occupancy !== 4'd3 || out_pc !== 32'h3004) begin
            errors++; $display("FAIL pp_setup: got occ=%0d pc=%h expected 3 00003004", occupancy, out_pc); end
        drive_pair(32'h3010); tick();
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (occupancy !== 4'd4 || out_pc !== 32'h3008 || out_inst !== tag(32'h3008)) begin
            errors++; $display("FAIL pp_net: got occ=%0d %h/%h expected 4 00003008/%h", occupancy, out_pc, out_inst, tag(32'h3008)); end
    endtask

    task automatic test_flush_reset();
        drive_pair(32'h3018); tick();
        in_valid = 1'b0; out_ready = 1'b1; tick();
        checks++; if (occupancy !== 4'd5) begin errors++; $display("FAIL flush_setup: got %0d expected 5", occupancy); end
        flush = 1'b1; drive_pair(32'h4000); out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (occupancy !== 4'd0 || out_valid !== 1'b0 || in_stall !== 1'b0) begin
            errors++; $display("FAIL flush_state: got occ=%0d v=%b stall=%b expected 0 0 0", occupancy, out_valid, in_stall); end
        drive_pair(32'h5000); tick();
        in_valid = 1'b0;
        checks++; if (occupancy !== 4'd2 || out_pc !== 32'h5000 || out_inst !== tag(32'h5000)) begin
            errors++; $display("FAIL post_flush: got occ=%0d %h/%h expected 2 00005000/%h", occupancy, out_pc, out_inst, tag(32'h5000)); end
        rst = 1'b1; drive_pair(32'h6000); out_ready = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (occupancy !== 4'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL midrst: got occ=%0d v=%b expected 0 0", occupancy, out_valid); end
        tick();
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL midrst_hold: got %0d expected 0", occupancy); end
    endtask

    task automatic test_wrap();
        int  pair_idx = 0;
        int  out_idx  = 0;
        int  model    = 0;
        int  cyc      = 0;
        logic model_stall;
        logic do_pop;
        logic do_push;
        while (out_idx < 40 && cyc < 400) begin
            model_stall = (int'(DEPTH) - model) < 2;
            checks++; if (occupancy !== (AW+1)'(model) || in_stall !== model_stall) begin
                errors++; $display("FAIL wrap_state[%0d]: got occ=%0d stall=%b expected %0d %b", cyc, occupancy, in_stall, model, model_stall); end
            out_ready = (cyc % 2 == 0);
            do_pop = (model != 0) && out_ready;
            if (do_pop) begin
                checks++; if (out_pc !== 32'(4 * out_idx) || out_inst !== tag(32'(4 * out_idx))) begin
                    errors++; $display("FAIL wrap_out[%0d]: got %h/%h expected %h/%h", out_idx, out_pc, out_inst,
                                       32'(4 * out_idx), tag(32'(4 * out_idx))); end
                out_idx++;
            end
            do_push = (pair_idx < 20) && !model_stall;
            if (pair_idx < 20) drive_pair(32'(8 * pair_idx));
            else in_valid = 1'b0;
            tick();
            if (do_push) pair_idx++;
            model = model + (do_push ? 2 : 0) - (do_pop ? 1 : 0);
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (out_idx != 40) begin errors++; $display("FAIL wrap_timeout: got %0d outputs expected 40", out_idx); end
        checks++; if (occupancy !== 4'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL wrap_empty: got occ=%0d v=%b expected 0 0", occupancy, out_valid); end
    endtask

    task automatic test_nop_words();
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h200; in_inst1 = 32'h0; in_inst2 = 32'h2003_0003;
        tick();
`ifdef NOP_SQUASH_EN
        checks++; if (occupancy !== 4'd1 || out_pc !== 32'h204 || out_inst !== 32'h2003_0003) begin
            errors++; $display("FAIL nop_one: got occ=%0d %h/%h expected 1 00000204/20030003", occupancy, out_pc, out_inst); end
        in_pc = 32'h208; in_inst1 = 32'h0; in_inst2 = 32'h0;
        tick();
        checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL nop_both: got %0d expected 1", occupancy); end
        in_pc = 32'h210; in_inst1 = 32'h11; in_inst2 = 32'h0;
        tick();
        in_valid = 1'b0;
        checks++; if (occupancy !== 4'd2) begin errors++; $display("FAIL nop_second: got %0d expected 2", occupancy); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_pc !== 32'h210 || out_inst !== 32'h11) begin
            errors++; $display("FAIL nop_order: got %h/%h expected 00000210/00000011", out_pc, out_inst); end
`else
        in_valid = 1'b0;
        checks++; if (occupancy !== 4'd2 || out_pc !== 32'h200 || out_inst !== 32'h0) begin
            errors++; $display("FAIL nop_kept: got occ=%0d %h/%h expected 2 00000200/00000000", occupancy, out_pc, out_inst); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_pc !== 32'h204 || out_inst !== 32'h2003_0003) begin
            errors++; $display("FAIL nop_second: got %h/%h expected 00000204/20030003", out_pc, out_inst); end
`endif
        tick();
        checks++; if (out_valid !== 1'b0 || occupancy !== 4'd0) begin
            errors++; $display("FAIL nop_empty: got v=%b occ=%0d expected 0 0", out_valid, occupancy); end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_stall();
        test_push_pop_same_cycle();
        test_flush_reset();
        test_wrap();
        test_nop_words();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
